// File: rtl/cell_pkg.sv
// Shared definitions for the S2-style sequential cells.
// Mode encoding produced by the select decoder.
package cell_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD  = 2'b00;
   localparam mode_t MODE_LOAD  = 2'b01;
   localparam mode_t MODE_SHIFT = 2'b10;
   localparam mode_t MODE_COUNT = 2'b11;

endpackage

// File: rtl/cell_mode_dec.sv
// S2 select logic: sel1 = a1|b1, sel0 = a0&b0.
// Reusable by any cell that shares the four-input select scheme.
module cell_mode_dec
   import cell_pkg::*;
(
   input  logic  a1,
   input  logic  b1,
   input  logic  a0,
   input  logic  b0,
   output mode_t mode
);

   assign mode = {a1 | b1, a0 & b0};

endmodule

// File: rtl/seq_cell_counter.sv
// WIDTH-bit hold/load/shift/modulo-count cell with
// terminal-count, wrap-pulse and sticky-overflow status.
module seq_cell_counter
   import cell_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MODULO     = 2 ** WIDTH,
   parameter int RESET_VAL  = 0,
   parameter int SHIFT_LEFT = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             a1,
   input  logic             b1,
   input  logic             a0,
   input  logic             b0,
   input  logic             up,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   // One extra bit so MODULO == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULO);
   localparam logic [WIDTH:0]   MAX_X = MOD_X - 1'b1;
   localparam logic [WIDTH-1:0] MAX_Q = MAX_X[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

   mode_t            mode;
   logic [WIDTH:0]   q_x;
   logic [WIDTH:0]   d_x;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             ovf_nxt;
   logic [WIDTH-1:0] shifted;

   cell_mode_dec u_dec (
      .a1   (a1),
      .b1   (b1),
      .a0   (a0),
      .b0   (b0),
      .mode (mode)
   );

   assign q_x = {1'b0, q};
   assign d_x = {1'b0, d};

   assign shifted = (SHIFT_LEFT != 0) ? {q[WIDTH-2:0], sin}
                                      : {sin, q[WIDTH-1:1]};

   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      ovf_nxt  = ovf;
      if (en) begin
         unique case (mode)
            MODE_HOLD: begin
               q_nxt = q;
            end
            MODE_LOAD: begin
               if (d_x < MOD_X) begin
                  q_nxt   = d;
                  ovf_nxt = 1'b0;
               end else begin
                  q_nxt   = MAX_Q;
                  ovf_nxt = 1'b1;
               end
            end
            MODE_SHIFT: begin
               q_nxt = shifted;
            end
            MODE_COUNT: begin
               if (up) begin
                  if (q_x >= MAX_X) begin
                     q_nxt    = '0;
                     wrap_nxt = 1'b1;
                     ovf_nxt  = 1'b1;
                  end else begin
                     q_nxt = q + WIDTH'(1);
                  end
               end else begin
                  if (q == '0) begin
                     q_nxt    = MAX_Q;
                     wrap_nxt = 1'b1;
                     ovf_nxt  = 1'b1;
                  end else begin
                     q_nxt = q - WIDTH'(1);
                  end
               end
            end
            default: begin
               q_nxt = q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q    <= RST_Q;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
         ovf  <= ovf_nxt;
      end
   end

   assign sout = (SHIFT_LEFT != 0) ? q[WIDTH-1] : q[0];
   assign tc   = up ? (q_x == MAX_X) : (q == '0);

endmodule
